// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher: one memory read per instruction,
// one-entry output buffer towards decode, redirect support with response kill.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | just out of reset; moves to REQ on the next clock
// REQ     | issue a read at pc (held off while a redirect is applied)
// WAIT    | read outstanding; kill set means the response gets dropped
// HOLD    | instruction buffered and offered to decode until accepted
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc
);

    fetch_state_t     state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] instr_nxt, instr_pc_nxt;
    logic [WIDTH-1:0] target_aligned;
    logic             kill, kill_nxt;
    logic             instr_valid_nxt;
    logic             unused_target_lsbs;

    assign target_aligned     = {redirect_target[WIDTH-1:2], 2'b00};
    assign unused_target_lsbs = ^redirect_target[1:0];

    // A redirect in REQ suppresses the request so the read goes out at the new pc.
    assign imem_req  = (state == ST_REQ) && !redirect_valid;
    assign imem_addr = imem_req ? pc : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            kill        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            kill        <= kill_nxt;
            instr_valid <= instr_valid_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        kill_nxt        = kill;
        instr_valid_nxt = instr_valid;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;

        unique case (state)
            ST_IDLE: begin
                if (redirect_valid) pc_nxt = target_aligned;
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid) pc_nxt = target_aligned;
                else                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect_valid) pc_nxt = target_aligned;
                if (imem_rvalid) begin
                    kill_nxt = 1'b0;
                    if (kill || redirect_valid) begin
                        state_nxt = ST_REQ;
                    end else begin
                        instr_nxt       = imem_rdata;
                        instr_pc_nxt    = pc;
                        instr_valid_nxt = 1'b1;
                        state_nxt       = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                // Redirect wins over a same-cycle handshake: the buffered
                // instruction is on the wrong path, so no pc+4.
                if (redirect_valid) begin
                    pc_nxt          = target_aligned;
                    instr_valid_nxt = 1'b0;
                    state_nxt       = ST_REQ;
                end else if (instr_valid && instr_ready) begin
                    pc_nxt          = pc + WIDTH'(INSTR_BYTES);
                    instr_valid_nxt = 1'b0;
                    state_nxt       = ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with programmable latency,
// request/delivery scoreboard, and directed scenario tasks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    // second instance exercising the pc wrap from a high reset vector
    logic        rst_w = 1'b1;
    logic        redir_w = 1'b0;
    logic [31:0] redir_tgt_w = '0;
    logic        req_w;
    logic [31:0] addr_w;
    logic        rvalid_w = 1'b0;
    logic [31:0] rdata_w = '0;
    logic        ivalid_w;
    logic        ready_w = 1'b0;
    logic [31:0] instr_w;
    logic [31:0] ipc_w;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    bit          mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    bit          sb_on = 1'b0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    int          req_cyc_q[$];
    logic [31:0] sb_a, sb_p;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst_w),
        .redirect_valid(redir_w), .redirect_target(redir_tgt_w),
        .imem_req(req_w), .imem_addr(addr_w),
        .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
        .instr_valid(ivalid_w), .instr_ready(ready_w),
        .instr(instr_w), .instr_pc(ipc_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // memory: response arrives mem_lat cycles after the request cycle
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_pend    = 1'b0;
            end
        end
        if (imem_req && !rst) begin
            checks++;
            if (mem_pend) begin
                errors++;
                $display("FAIL single_outstanding: request at 0x%08h while 0x%08h pending", imem_addr, mem_addr);
            end
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = imem_addr;
        end
    end

    // scoreboard: requests and accepted instructions against pushed expectations
    always @(negedge clk) begin
        if (sb_on && !rst) begin
            if (imem_req) begin
                req_cyc_q.push_back(cyc);
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_req: unexpected request at 0x%08h", imem_addr);
                end else begin
                    sb_a = exp_addr_q.pop_front();
                    if (imem_addr !== sb_a) begin
                        errors++;
                        $display("FAIL sb_req: imem_addr=0x%08h, required 0x%08h", imem_addr, sb_a);
                    end
                end
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                checks++;
                if (exp_pc_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_instr: unexpected delivery pc=0x%08h", instr_pc);
                end else begin
                    sb_p = exp_pc_q.pop_front();
                    if ({instr_pc, instr} !== {sb_p, mem_word(sb_p)}) begin
                        errors++;
                        $display("FAIL sb_instr: pc=0x%08h instr=0x%08h, required pc=0x%08h instr=0x%08h",
                                 instr_pc, instr, sb_p, mem_word(sb_p));
                    end
                end
            end
        end
    end

    task automatic hold_reset();
        sb_on           = 1'b0;
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        instr_ready     = 1'b0;
        repeat (6) @(posedge clk);
        exp_addr_q.delete();
        exp_pc_q.delete();
        req_cyc_q.delete();
        #1;
    endtask

    // returns at posedge+1 once every expected delivery has been seen (or budget spent)
    task automatic wait_drain(input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((exp_pc_q.size() != 0 || exp_addr_q.size() != 0) && n < budget);
        sb_on = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset();
        checks++;
        if ({imem_req, instr_valid, imem_addr, instr, instr_pc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b valid=%b addr=0x%08h instr=0x%08h pc=0x%08h, required all 0",
                     imem_req, instr_valid, imem_addr, instr, instr_pc);
        end
        checks++;
        if ({req_w, ivalid_w, addr_w, instr_w, ipc_w} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_wrap: req=%b valid=%b addr=0x%08h instr=0x%08h pc=0x%08h, required all 0",
                     req_w, ivalid_w, addr_w, instr_w, ipc_w);
        end
    endtask

    task automatic test_stream();
        hold_reset();
        mem_lat     = 1;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_pc_q.push_back(32'(i * 4));
        end
        sb_on = 1'b1;
        rst   = 1'b0;
        wait_drain(60);
        instr_ready = 1'b0;
        checks++;
        if (exp_pc_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: %0d addr / %0d instr outstanding, required 0", exp_addr_q.size(), exp_pc_q.size());
        end
        checks++;
        if (req_cyc_q.size() != 3) begin
            errors++;
            $display("FAIL stream_req_count: %0d requests, required 3", req_cyc_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (req_cyc_q[i] - req_cyc_q[i-1] != 3) begin
                    errors++;
                    $display("FAIL stream_spacing: %0d cycles between requests, required 3", req_cyc_q[i] - req_cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int n = 0;
        hold_reset();
        mem_lat = 1;
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_pc_q.push_back(32'h0);
        exp_pc_q.push_back(32'h4);
        sb_on = 1'b1;
        rst   = 1'b0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({instr_valid, imem_req, instr_pc, instr} !== {1'b1, 1'b0, 32'h0, mem_word(32'h0)}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b req=%b pc=0x%08h instr=0x%08h, required 1 0 0x00000000 0x%08h",
                         i, instr_valid, imem_req, instr_pc, instr, mem_word(32'h0));
            end
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        wait_drain(40);
        instr_ready = 1'b0;
        checks++;
        if (exp_pc_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: %0d addr / %0d instr outstanding, required 0", exp_addr_q.size(), exp_pc_q.size());
        end
    endtask

    task automatic test_redirect_wait();
        int n = 0;
        int stale = 0;
        hold_reset();
        mem_lat     = 4;
        instr_ready = 1'b1;
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h100);
        exp_pc_q.push_back(32'h100);
        sb_on = 1'b1;
        rst   = 1'b0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        n = 0;
        while (exp_addr_q.size() != 0 && n < 20) begin
            @(negedge clk);
            if (instr_valid) stale++;
            n++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL redirect_wait_stale: instr_valid seen %0d cycles before new request, required 0", stale);
        end
        wait_drain(60);
        instr_ready = 1'b0;
        checks++;
        if (exp_pc_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL redirect_wait_drain: %0d addr / %0d instr outstanding, required 0", exp_addr_q.size(), exp_pc_q.size());
        end
    endtask

    task automatic test_redirect_coincident();
        int n = 0;
        hold_reset();
        mem_lat     = 1;
        instr_ready = 1'b1;
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h40);
        exp_pc_q.push_back(32'h40);
        sb_on = 1'b1;
        rst   = 1'b0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h41;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_drain(40);
        instr_ready = 1'b0;
        checks++;
        if (exp_pc_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL redirect_coincident_drain: %0d addr / %0d instr outstanding, required 0", exp_addr_q.size(), exp_pc_q.size());
        end
    endtask

    task automatic test_redirect_hold();
        int n = 0;
        hold_reset();
        mem_lat = 1;
        exp_addr_q.push_back(32'h20);
        exp_addr_q.push_back(32'h200);
        sb_on           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h22;
        rst             = 1'b0;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h20}) begin
            errors++;
            $display("FAIL redirect_hold_setup: valid=%b pc=0x%08h, required 1 0x00000020", instr_valid, instr_pc);
        end
        @(posedge clk);
        #1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h203;
        instr_ready     = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        @(negedge clk);
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
            errors++;
            $display("FAIL redirect_hold: valid=%b req=%b addr=0x%08h, required 0 1 0x00000200", instr_valid, imem_req, imem_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        sb_on = 1'b0;
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL redirect_hold_drain: %0d requests outstanding, required 0", exp_addr_q.size());
        end
    endtask

    task automatic test_wrap();
        ready_w = 1'b1;
        @(posedge clk);
        #1 rst_w = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({req_w, addr_w} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_first_req: req=%b addr=0x%08h, required 1 0xfffffffc", req_w, addr_w);
        end
        @(posedge clk);
        #1;
        rvalid_w = 1'b1;
        rdata_w  = 32'hCAFE_F00D;
        @(posedge clk);
        #1 rvalid_w = 1'b0;
        @(negedge clk);
        checks++;
        if ({ivalid_w, ipc_w, instr_w} !== {1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL wrap_instr: valid=%b pc=0x%08h instr=0x%08h, required 1 0xfffffffc 0xcafef00d", ivalid_w, ipc_w, instr_w);
        end
        @(negedge clk);
        checks++;
        if ({req_w, addr_w} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_second_req: req=%b addr=0x%08h, required 1 0x00000000", req_w, addr_w);
        end
        ready_w = 1'b0;
        rst_w   = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        hold_reset();
        mem_lat     = 3;
        instr_ready = 1'b1;
        exp_addr_q.push_back(32'h0);
        sb_on = 1'b1;
        rst   = 1'b0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, instr_valid, imem_addr, instr, instr_pc} !== '0) begin
            errors++;
            $display("FAIL reset_async: req=%b valid=%b addr=0x%08h instr=0x%08h pc=0x%08h, required all 0",
                     imem_req, instr_valid, imem_addr, instr, instr_pc);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({imem_req, instr_valid, imem_addr, instr, instr_pc} !== '0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: req=%b valid=%b addr=0x%08h instr=0x%08h pc=0x%08h, required all 0",
                         i, imem_req, instr_valid, imem_addr, instr, instr_pc);
            end
        end
        exp_addr_q.push_back(32'h0);
        exp_pc_q.push_back(32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_drain(40);
        instr_ready = 1'b0;
        checks++;
        if (exp_pc_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_wait_drain: %0d addr / %0d instr outstanding, required 0", exp_addr_q.size(), exp_pc_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_coincident();
        test_redirect_hold();
        test_wrap();
        test_reset_mid_wait();
        hold_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
